// File: rtl/banked_wb_ram_pkg.sv
// banked_wb_ram_pkg: shared constants, index-width helper and pending-ack record
package banked_wb_ram_pkg;
  localparam int BANK_WORDS = 256;
  localparam int WORD_W = 32;
  localparam int SEL_W = 4;
  localparam int BANK_IDX_MAX_W = 3;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int bank_idx_w(input int num_banks);
    return idx_w(num_banks);
  endfunction
  function automatic int port_idx_w(input int num_ports);
    return idx_w(num_ports);
  endfunction
  typedef struct packed {
    logic valid;
    logic we;
    logic [BANK_IDX_MAX_W-1:0] bank_idx;
  } pend_t;
endpackage

// File: rtl/banked_wb_ram_if.sv
// banked_wb_ram_if: per-port pipelined Wishbone bundle for banked_wb_ram
//   master drives cyc/stb/we/addr/data/sel; slave returns ack/stall/read data
interface banked_wb_ram_if
  import banked_wb_ram_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W = 11
);
  logic [NUM_PORTS-1:0] wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o, wb_stall_o;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] wb_addr_i;
  logic [NUM_PORTS-1:0][WORD_W-1:0] wb_data_i, wb_data_o;
  logic [NUM_PORTS-1:0][SEL_W-1:0] wb_sel_i;
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
    input wb_ack_o, wb_stall_o, wb_data_o
  );
  modport slave (
    input wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
    output wb_ack_o, wb_stall_o, wb_data_o
  );
endinterface

// File: rtl/banked_wb_ram_rr_arbiter.sv
// banked_wb_ram_rr_arbiter: N-way round-robin arbiter, one grant per cycle
//   clk_i/rst_ni: clock, async active-low reset; req_i: requests
//   gnt_o: one-hot grant; gnt_valid_o: some request granted
module banked_wb_ram_rr_arbiter
  import banked_wb_ram_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         gnt_valid_o
);
  assign gnt_valid_o = |req_i;
  if (N == 1) begin : g_single
    assign gnt_o = req_i;
  end else begin : g_rr
    localparam int PW = port_idx_w(N);
    logic [PW-1:0] ptr_q, ptr_d;
    // winner is the requester at the smallest circular distance from ptr_q
    always_comb begin
      int best, g, d;
      best = N;
      g = 0;
      d = 0;
      for (int p = 0; p < N; p++) begin
        d = (p + N - int'(ptr_q)) % N;
        if (req_i[p] && d < best) begin
          best = d;
          g = p;
        end
      end
      gnt_o = gnt_valid_o ? N'(1) << g : '0;
      ptr_d = PW'((g + 1) % N);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= '0;
      else if (gnt_valid_o) ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/banked_wb_ram.sv
// banked_wb_ram: N-port, M-bank pipelined Wishbone SRAM with per-bank round-robin arbitration
//   clk_i: clock; rst_ni: async active-low reset
//   wb: slave side of banked_wb_ram_if (cyc/stb/we/addr/data/sel in, ack/stall/data out)
module banked_wb_ram
  import banked_wb_ram_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W = 10 + $clog2(NUM_BANKS)
) (
  input logic clk_i,
  input logic rst_ni,
  banked_wb_ram_if.slave wb
);
  localparam int BW = bank_idx_w(NUM_BANKS);
  logic [NUM_PORTS-1:0] req_v, acc;
  logic [NUM_PORTS-1:0][BW-1:0] bsel;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0] req, gnt;
  logic [NUM_BANKS-1:0] bank_en;
  logic [NUM_BANKS-1:0][7:0] bank_a;
  logic [NUM_BANKS-1:0][WORD_W-1:0] bank_di, bank_do;
  logic [NUM_BANKS-1:0][SEL_W-1:0] bank_we;
  pend_t [NUM_PORTS-1:0] pend_q, pend_d;
  assign req_v = wb.wb_cyc_i & wb.wb_stb_i;
  assign wb.wb_stall_o = req_v & ~acc;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic unused_bits;
    if (NUM_BANKS > 1) begin : g_sel
      assign bsel[p] = wb.wb_addr_i[p][ADDR_W-1:10];
    end else begin : g_nosel
      assign bsel[p] = '0;
    end
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_req
      assign req[b][p] = req_v[p] && bsel[p] == BW'(b);
    end
    assign pend_d[p] = '{valid: acc[p], we: wb.wb_we_i[p], bank_idx: BANK_IDX_MAX_W'(bsel[p])};
    assign wb.wb_ack_o[p] = pend_q[p].valid;
    assign wb.wb_data_o[p] = (pend_q[p].valid && !pend_q[p].we) ? bank_do[pend_q[p].bank_idx[BW-1:0]] : '0;
    assign unused_bits = ^{wb.wb_addr_i[p][1:0], pend_q[p].bank_idx};
  end
  // each port targets at most one bank, so OR-ing bank grants gives per-port acceptance
  always_comb begin
    acc = '0;
    for (int b = 0; b < NUM_BANKS; b++) acc |= gnt[b];
  end
  always_comb begin
    bank_a = '0;
    bank_di = '0;
    bank_we = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int p = 0; p < NUM_PORTS; p++)
        if (gnt[b][p]) begin
          bank_a[b] = wb.wb_addr_i[p][9:2];
          bank_di[b] = wb.wb_data_i[p];
          bank_we[b] = wb.wb_sel_i[p] & {SEL_W{wb.wb_we_i[p]}};
        end
  end
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [WORD_W-1:0] mem [BANK_WORDS];
    logic [WORD_W-1:0] rd_q;
    banked_wb_ram_rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req_i      (req[b]),
      .gnt_o      (gnt[b]),
      .gnt_valid_o(bank_en[b])
    );
    // behavioural DFFRAM256x32: no reset, byte write enables, registered read of old data
    always_ff @(posedge clk_i) begin
      if (bank_en[b]) begin
        for (int k = 0; k < SEL_W; k++)
          if (bank_we[b][k]) mem[bank_a[b]][8*k +: 8] <= bank_di[b][8*k +: 8];
        rd_q <= mem[bank_a[b]];
      end
    end
    assign bank_do[b] = rd_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend_q <= '0;
    else pend_q <= pend_d;
  end
endmodule

// File: tb/tb_banked_wb_ram.sv
// tb_banked_wb_ram: self-checking bench for banked_wb_ram against a word-array reference model
module tb_banked_wb_ram;
  localparam int NP = 2;
  localparam int NB = 2;
  localparam int AW = 11;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vec = 0;
  int errs = 0;
  logic [31:0] mem_m [NB*256];
  always #5 clk = ~clk;
  banked_wb_ram_if #(.NUM_PORTS(NP), .ADDR_W(AW)) wb();
  banked_wb_ram #(.NUM_PORTS(NP), .NUM_BANKS(NB), .ADDR_W(AW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .wb    (wb)
  );

  function automatic int widx(input logic [AW-1:0] a);
    return int'(a[AW-1:2]);
  endfunction
  function automatic void mwrite(input int i, input logic [31:0] d, input logic [3:0] sl);
    for (int k = 0; k < 4; k++) if (sl[k]) mem_m[i][8*k +: 8] = d[8*k +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wb.wb_cyc_i = '0; wb.wb_stb_i = '0; wb.wb_we_i = '0;
    wb.wb_addr_i = '0; wb.wb_data_i = '0; wb.wb_sel_i = '0;
  endtask
  task automatic drive(input int p, input logic c, input logic s, input logic w,
                       input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] sl);
    wb.wb_cyc_i[p] = c; wb.wb_stb_i[p] = s; wb.wb_we_i[p] = w;
    wb.wb_addr_i[p] = a; wb.wb_data_i[p] = d; wb.wb_sel_i[p] = sl;
  endtask
  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] sl);
    drive(p, 1'b1, 1'b1, 1'b1, a, d, sl);
    mwrite(widx(a), d, sl);
    step();
    idle();
  endtask
  task automatic rd1(input int p, input logic [AW-1:0] a, output logic st, output logic ak, output logic [31:0] dt);
    drive(p, 1'b1, 1'b1, 1'b0, a, 32'h0, 4'hF);
    @(negedge clk);
    st = wb.wb_stall_o[p];
    step();
    ak = wb.wb_ack_o[p];
    dt = wb.wb_data_o[p];
    idle();
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle();
    step();
    vec++; if (wb.wb_ack_o !== 2'b00) begin errs++; $display("FAIL reset_ack: got %b expected 00", wb.wb_ack_o); end
    vec++; if (wb.wb_data_o !== '0) begin errs++; $display("FAIL reset_data: got %h expected 0", wb.wb_data_o); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    vec++; if (wb.wb_stall_o !== 2'b00) begin errs++; $display("FAIL idle_stall: got %b expected 00", wb.wb_stall_o); end
    vec++; if (wb.wb_ack_o !== 2'b00) begin errs++; $display("FAIL idle_ack: got %b expected 00", wb.wb_ack_o); end
  endtask

  task automatic test_single();
    logic st, ak;
    logic [31:0] dt;
    drive(0, 1'b1, 1'b1, 1'b1, 11'h004, 32'hDEADBEEF, 4'hF);
    mwrite(widx(11'h004), 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    vec++; if (wb.wb_stall_o !== 2'b00) begin errs++; $display("FAIL single_wr_stall: got %b expected 00", wb.wb_stall_o); end
    step();
    idle();
    vec++; if (wb.wb_ack_o !== 2'b01) begin errs++; $display("FAIL single_wr_ack: got %b expected 01", wb.wb_ack_o); end
    vec++; if (wb.wb_data_o[0] !== 32'h0) begin errs++; $display("FAIL single_wr_data_gated: got %h expected 0", wb.wb_data_o[0]); end
    step();
    vec++; if (wb.wb_ack_o !== 2'b00) begin errs++; $display("FAIL single_ack_one_cycle: got %b expected 00", wb.wb_ack_o); end
    rd1(0, 11'h004, st, ak, dt);
    vec++; if (st !== 1'b0) begin errs++; $display("FAIL single_rd_stall: got %b expected 0", st); end
    vec++; if (ak !== 1'b1) begin errs++; $display("FAIL single_rd_ack: got %b expected 1", ak); end
    vec++; if (dt !== mem_m[widx(11'h004)]) begin errs++; $display("FAIL single_rd_data: got %h expected %h", dt, mem_m[widx(11'h004)]); end
    step();
    vec++; if (wb.wb_data_o[0] !== 32'h0) begin errs++; $display("FAIL single_data_after_ack: got %h expected 0", wb.wb_data_o[0]); end
  endtask

  task automatic test_byte_lanes();
    logic st, ak;
    logic [31:0] dt;
    wr(0, 11'h408, 32'h11223344, 4'hF);
    wr(0, 11'h408, 32'hAABBCCDD, 4'b0101);
    rd1(0, 11'h408, st, ak, dt);
    vec++; if (dt !== 32'h11BB33DD) begin errs++; $display("FAIL byte_lanes: got %h expected 11bb33dd", dt); end
    rd1(0, 11'h408, st, ak, dt);
    vec++; if (dt !== mem_m[widx(11'h408)]) begin errs++; $display("FAIL read_no_write: got %h expected %h", dt, mem_m[widx(11'h408)]); end
  endtask

  task automatic test_parallel();
    wr(0, 11'h010, 32'h0BADF00D, 4'hF);
    wr(0, 11'h410, 32'hCAFEF00D, 4'hF);
    drive(0, 1'b1, 1'b1, 1'b0, 11'h010, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b1, 1'b0, 11'h410, 32'h0, 4'hF);
    @(negedge clk);
    vec++; if (wb.wb_stall_o !== 2'b00) begin errs++; $display("FAIL par_stall: got %b expected 00", wb.wb_stall_o); end
    step();
    idle();
    vec++; if (wb.wb_ack_o !== 2'b11) begin errs++; $display("FAIL par_ack: got %b expected 11", wb.wb_ack_o); end
    vec++; if (wb.wb_data_o[0] !== mem_m[widx(11'h010)]) begin errs++; $display("FAIL par_data0: got %h expected %h", wb.wb_data_o[0], mem_m[widx(11'h010)]); end
    vec++; if (wb.wb_data_o[1] !== mem_m[widx(11'h410)]) begin errs++; $display("FAIL par_data1: got %h expected %h", wb.wb_data_o[1], mem_m[widx(11'h410)]); end
    step();
  endtask

  task automatic test_contention();
    int cnt [NP];
    int w;
    logic [AW-1:0] a [NP];
    a[0] = 11'h020;
    a[1] = 11'h024;
    cnt[0] = 0;
    cnt[1] = 0;
    wr(0, a[0], 32'h00C0FFEE, 4'hF);
    wr(1, a[1], 32'h0DEC0DE0, 4'hF);
    pulse_reset();
    for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b1, 1'b0, a[p], 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      w = i % 2;
      @(negedge clk);
      vec++; if (wb.wb_stall_o !== NP'(1 << (1 - w))) begin errs++; $display("FAIL cont_stall[%0d]: got %b expected %b", i, wb.wb_stall_o, NP'(1 << (1 - w))); end
      step();
      if (wb.wb_ack_o[0]) cnt[0]++;
      if (wb.wb_ack_o[1]) cnt[1]++;
      vec++; if (wb.wb_ack_o !== NP'(1 << w)) begin errs++; $display("FAIL cont_ack[%0d]: got %b expected %b", i, wb.wb_ack_o, NP'(1 << w)); end
      vec++; if (wb.wb_data_o[w] !== mem_m[widx(a[w])]) begin errs++; $display("FAIL cont_data[%0d]: got %h expected %h", i, wb.wb_data_o[w], mem_m[widx(a[w])]); end
    end
    idle();
    vec++; if (cnt[0] !== 3) begin errs++; $display("FAIL cont_cnt0: got %0d expected 3", cnt[0]); end
    vec++; if (cnt[1] !== 3) begin errs++; $display("FAIL cont_cnt1: got %0d expected 3", cnt[1]); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    for (int k = 0; k < 4; k++) wr(1, AW'(11'h400 + 4 * k), $urandom, 4'hF);
    for (int k = 0; k < 4; k++) begin
      a = AW'(11'h400 + 4 * k);
      drive(1, 1'b1, 1'b1, 1'b0, a, 32'h0, 4'hF);
      @(negedge clk);
      vec++; if (wb.wb_stall_o[1] !== 1'b0) begin errs++; $display("FAIL burst_stall[%0d]: got %b expected 0", k, wb.wb_stall_o[1]); end
      step();
      vec++; if (wb.wb_ack_o[1] !== 1'b1) begin errs++; $display("FAIL burst_ack[%0d]: got %b expected 1", k, wb.wb_ack_o[1]); end
      vec++; if (wb.wb_data_o[1] !== mem_m[widx(a)]) begin errs++; $display("FAIL burst_data[%0d]: got %h expected %h", k, wb.wb_data_o[1], mem_m[widx(a)]); end
    end
    drive(1, 1'b0, 1'b1, 1'b0, 11'h400, 32'h0, 4'hF);
    @(negedge clk);
    vec++; if (wb.wb_stall_o[1] !== 1'b0) begin errs++; $display("FAIL stb_no_cyc_stall: got %b expected 0", wb.wb_stall_o[1]); end
    step();
    idle();
    vec++; if (wb.wb_ack_o[1] !== 1'b0) begin errs++; $display("FAIL stb_no_cyc_ack: got %b expected 0", wb.wb_ack_o[1]); end
    step();
  endtask

  task automatic test_reset_mid();
    drive(0, 1'b1, 1'b1, 1'b0, 11'h004, 32'h0, 4'hF);
    @(negedge clk);
    rst_n = 1'b0;
    step();
    idle();
    vec++; if (wb.wb_ack_o !== 2'b00) begin errs++; $display("FAIL rst_mid_ack: got %b expected 00", wb.wb_ack_o); end
    vec++; if (wb.wb_data_o[0] !== 32'h0) begin errs++; $display("FAIL rst_mid_data: got %h expected 0", wb.wb_data_o[0]); end
    step();
    vec++; if (wb.wb_ack_o !== 2'b00) begin errs++; $display("FAIL rst_hold_ack: got %b expected 00", wb.wb_ack_o); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    drive(0, 1'b1, 1'b1, 1'b0, 11'h020, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b1, 1'b0, 11'h024, 32'h0, 4'hF);
    @(negedge clk);
    vec++; if (wb.wb_stall_o !== 2'b10) begin errs++; $display("FAIL post_rst_stall: got %b expected 10", wb.wb_stall_o); end
    step();
    idle();
    vec++; if (wb.wb_ack_o !== 2'b01) begin errs++; $display("FAIL post_rst_ack: got %b expected 01", wb.wb_ack_o); end
    vec++; if (wb.wb_data_o[0] !== mem_m[widx(11'h020)]) begin errs++; $display("FAIL post_rst_data: got %h expected %h", wb.wb_data_o[0], mem_m[widx(11'h020)]); end
    step();
  endtask

  task automatic test_random();
    logic [NP-1:0] hold, exp_stall, exp_ack;
    logic [31:0] exp_dat [NP];
    int prio [NB];
    int win, p, i;
    for (int k = 0; k < NB * 8; k++) wr(0, AW'(((k / 8) << 10) | ((k % 8) << 2)), $urandom, 4'hF);
    pulse_reset();
    for (int b = 0; b < NB; b++) prio[b] = 0;
    hold = '0;
    for (int c = 0; c < 300; c++) begin
      for (int q = 0; q < NP; q++)
        if (!hold[q])
          drive(q, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 1'($urandom),
                AW'((($urandom % NB) << 10) | (($urandom % 8) << 2) | ($urandom % 4)), $urandom, 4'($urandom));
      exp_stall = '0;
      exp_ack = '0;
      for (int q = 0; q < NP; q++) exp_dat[q] = 32'h0;
      for (int b = 0; b < NB; b++) begin
        win = -1;
        for (int k = 0; k < NP; k++) begin
          p = (prio[b] + k) % NP;
          if (wb.wb_cyc_i[p] && wb.wb_stb_i[p] && int'(wb.wb_addr_i[p][10]) == b) begin
            if (win < 0) win = p;
            else exp_stall[p] = 1'b1;
          end
        end
        if (win >= 0) begin
          i = widx(wb.wb_addr_i[win]);
          exp_ack[win] = 1'b1;
          if (wb.wb_we_i[win]) mwrite(i, wb.wb_data_i[win], wb.wb_sel_i[win]);
          else exp_dat[win] = mem_m[i];
          prio[b] = (win + 1) % NP;
        end
      end
      @(negedge clk);
      vec++; if (wb.wb_stall_o !== exp_stall) begin errs++; $display("FAIL rand_stall[%0d]: got %b expected %b", c, wb.wb_stall_o, exp_stall); end
      step();
      vec++; if (wb.wb_ack_o !== exp_ack) begin errs++; $display("FAIL rand_ack[%0d]: got %b expected %b", c, wb.wb_ack_o, exp_ack); end
      for (int q = 0; q < NP; q++) begin
        vec++; if (wb.wb_data_o[q] !== exp_dat[q]) begin errs++; $display("FAIL rand_data[%0d][%0d]: got %h expected %h", c, q, wb.wb_data_o[q], exp_dat[q]); end
      end
      hold = exp_stall;
    end
    idle();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_byte_lanes();
    test_parallel();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/banked_wb_ram.md
Name: banked_wb_ram

Overview:
- Parametrised N-port, M-bank Wishbone (pipelined) SRAM built from DFFRAM256x32 macros.
- Each port can reach every bank. Each bank has an independent round-robin arbiter, so ports hitting different banks proceed in parallel with no stall.
- Successor to the fixed 2-port/2-bank shared RAM. Adds:
  - configurable port and bank counts;
  - fair N-way arbitration;
  - cyc qualification;
  - read-safe write enables;
  - reset.

Parameters:
NUM_PORTS, 2, number of Wishbone slave ports (1..8)
NUM_BANKS, 2, number of 256x32 banks; power of two (1..8)
ADDR_W, 10+$clog2(NUM_BANKS) (11 at defaults), byte address width; [1:0] ignored, [9:2] word in bank, [ADDR_W-1:10] bank select

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
wb_cyc_i  in  NUM_PORTS  per-port cycle
wb_stb_i  in  NUM_PORTS  per-port strobe
wb_we_i  in  NUM_PORTS  per-port write enable
wb_addr_i  in  NUM_PORTS x ADDR_W  per-port byte address
wb_data_i  in  NUM_PORTS x 32  per-port write data
wb_sel_i  in  NUM_PORTS x 4  per-port byte select
wb_ack_o  out  NUM_PORTS  per-port acknowledge
wb_stall_o  out  NUM_PORTS  per-port stall (combinational)
wb_data_o  out  NUM_PORTS x 32  per-port read data

Behaviour:
- Request definition: port p requests bank b when cyc&stb are high and addr[ADDR_W-1:10]==b. stb without cyc is ignored: no stall, no ack.
- Arbitration:
  - Per bank, combinational round-robin among requesters.
  - Pointer ptr[b] marks the highest-priority port; search order is ptr, ptr+1, ... mod NUM_PORTS.
  - On any grant to port g, ptr[b] <= (g+1) mod NUM_PORTS. Pointer holds when the bank is idle.
- Stall: wb_stall_o[p] = request && !granted. A stalled master holds its request, which is re-arbitrated next cycle. Under continuous contention, a requester waits at most NUM_PORTS-1 cycles.
- Bank drive for the granted port: EN=1, A0=addr[9:2], Di0=data, WE0=sel & {4{we}}. Reads never write (WE0=0). Ungranted banks: EN=0, WE0=0.
- Latency: request accepted (granted) in cycle N.
  - wb_ack_o[p]=1 in cycle N+1 only.
  - Read data appears on wb_data_o[p] in N+1, muxed from Do0 of the bank recorded in a registered bank index.
  - Writes ack identically.
- Pipelining: a port may issue back-to-back accepted requests every cycle, giving ack every cycle. Acks return in issue order.
- Data gating: wb_data_o[p]=0 whenever wb_ack_o[p]=0 and for write acks.
- Simultaneous events: ports targeting distinct banks are all granted the same cycle. Same bank with the same address: one winner per cycle, and the loser's access happens next cycle (read-after-write ordering follows grant order).
- Reset (async assert, sync deassert by system):
  - all wb_ack_o=0, wb_data_o=0, ptr[b]=0 (port 0 highest), pending-ack registers cleared.
  - Reset mid-transaction drops in-flight acks; the bank contents are undefined-but-unchanged, because the macro has no reset.
- Width rules: NUM_PORTS==1 means no arbitration logic and stall tied 0. NUM_BANKS==1 means the bank-select field is empty and ADDR_W=10.

Decomposition:
- Package banked_wb_ram_pkg:
  - BANK_WORDS=256, WORD_W=32, SEL_W=4;
  - localparam functions for bank-index width and port-index width;
  - typedef for the per-port pending record {valid, we, bank_idx}.
- Sub-module rr_arbiter (parameter N): inputs req[N] and clk/rst_ni; outputs one-hot gnt[N] and gnt_valid; owns its pointer. Instantiated once per bank.

Test Plan:
- Single port 0: write 0xDEADBEEF at byte addr 0x004 with sel=4'hF, then read 0x004 → ack exactly one cycle after each accept; read data 0xDEADBEEF; stall stays 0.
- Byte lanes: write 0x11223344 at 0x408, then write 0xAABBCCDD with sel=4'b0101 → read returns 0x11BB33DD. A read issued with sel=4'hF and we=0 does not alter memory.
- Parallel banks: port 0 reads 0x010 (bank 0) and port 1 reads 0x410 (bank 1) in the same cycle → both ack next cycle with correct data; neither stalls.
- Contention fairness: ports 0 and 1 hammer bank 0 continuously for 6 cycles from reset → grants alternate P0,P1,P0,P1,P0,P1; each port gets 3 acks; the loser sees stall=1 in the cycles it loses.
- Pipelined burst: port 1 issues 4 back-to-back reads 0x400..0x40C, uncontended → 4 consecutive acks with data in order; a cyc=0,stb=1 pulse in between produces no ack.
- Reset mid-operation: assert rst_ni=0 in the cycle after an accepted read → ack never asserts and wb_data_o=0. After release, the first contended access is granted to port 0.
